neighbor_exchange_controller: RTL and testbench
===============================================

NEIGHBOR_EXCHANGE_CONTROLLER -- requirements
Module: neighbor_exchange_controller

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 256, tile row/column range; RW = $clog2(TILE_SIZE).
REQ-002 SHALL have parameter LANES, default 8, neighbor lanes per batch; fixed at 8 for this revision.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a tile exchange, honoured only in IDLE.
REQ-005 abort  input  1  returns the FSM to IDLE at the next edge from any state.
REQ-006 expected_count  input  16  number of lane entries expected this tile; sampled on start.
REQ-007 bitwidth_in  input  2  precision mode; sampled on start.
REQ-008 in_valid / in_ready  input / output  1 / 1  batch handshake from the halo source.
REQ-009 in_value[8], in_row[8], in_column[8], in_lane_valid  input  8 / RW / RW / 8  per-lane batch payload.
REQ-010 leftover_inputs  input  1  neighbor processor busy resolving bank conflicts (registered in the processor).
REQ-011 neighbor_input_value[8], neighbor_input_row[8], neighbor_input_column[8], neighbor_input_write_enable  output  8 / RW / RW / 8  registered batch driven to the processor.
REQ-012 bitwidth  output  2  latched precision mode.
REQ-013 busy / done / overflow  output  1 / 1 / 1  state flags; done is a one-cycle pulse; overflow is sticky until the next start.
REQ-014 accepted_count / stall_cycles  output  16 / 16  lanes consumed; cycles held by leftover_inputs (saturating at 16'hFFFF).

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; busy = (state is RUN or DRAIN).
REQ-016 IDLE->RUN on start: latch expected_count and bitwidth_in; clear accepted_count, stall_cycles and overflow; clear the output register.
REQ-017 A batch SHALL be consumed in any cycle where neighbor_input_write_enable!=0 and leftover_inputs==0.
REQ-018 While leftover_inputs==1, all neighbor_input_* outputs SHALL hold stable and stall_cycles SHALL increment if the output register is non-empty.
REQ-019 in_ready = (state==RUN) and (output register empty or batch consumed this cycle), for a zero-bubble throughput of one batch per cycle.
REQ-020 On in_valid&&in_ready, the output register SHALL load the payload at the next edge; write_enable = in_lane_valid masked to the lowest-indexed lanes fitting the remaining count (expected_count - accepted_count - lanes in flight).
REQ-021 If any lane is masked per REQ-020, overflow SHALL set.
REQ-022 If a batch is consumed and no load occurs, write_enable SHALL clear to 0 at the next edge.
REQ-023 accepted_count SHALL add popcount(write_enable) on each consumed batch; arithmetic is 16-bit, and no wrap is possible because of REQ-020.
REQ-024 RUN->DRAIN when accepted_count plus in-flight lanes equals expected_count; in_ready SHALL then be 0.
REQ-025 An in_lane_valid==0 batch SHALL be accepted and dropped, with write_enable left 0.
REQ-026 DRAIN->DONE once the output register is empty and leftover_inputs==0; DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-027 expected_count==0 on start SHALL go RUN->DRAIN immediately, with done two cycles after start.
REQ-028 start while busy SHALL be ignored; abort and start in the same cycle resolves to abort.
REQ-029 On abort, the FSM SHALL go to IDLE and write_enable SHALL clear; counters hold their values for debug.

Reset
REQ-030 Asserting reset_n=0 SHALL asynchronously force: state IDLE; all outputs 0; in_ready 0; every counter 0; overflow 0.
REQ-031 Reset mid-tile SHALL discard the in-flight batch, with no re-issue after reset release.

Structure
REQ-032 Package utils SHALL hold NEIGHBOR_LANES=8 and the state typedef xchg_state_t {IDLE, RUN, DRAIN, DONE}.
REQ-033 A sub-module lane_popcount (8-bit in, 4-bit count, combinational) SHALL be used for REQ-020 and REQ-023.

Verification
REQ-034 expected_count=16; two full batches with no leftover -> consumed on consecutive cycles; accepted_count=16; done pulses 2 cycles after the last consume.
REQ-035 leftover_inputs held high 3 cycles after batch 1 -> outputs stable for 3 cycles; stall_cycles=3; in_ready low for 3 cycles; no batch lost.
REQ-036 expected_count=10; two batches of 8 lanes -> second write_enable=8'b00000011; overflow=1; accepted_count=10.
REQ-037 expected_count=0; start -> done asserted at start+2; no in_ready.
REQ-038 abort during RUN with batch pending -> write_enable=0 next cycle; state IDLE; a new start is accepted.
REQ-039 reset_n low mid-DRAIN, asynchronously between edges -> all outputs 0 immediately; done never pulses.

Source files
------------

// File: rtl/neighbor_exchange_controller_pkg.sv
// Shared definitions for the neighbor exchange controller: lane count and FSM state encoding.
package utils;

    localparam int NEIGHBOR_LANES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xchg_state_t;

endpackage

// File: rtl/neighbor_exchange_controller_if.sv
// Batch bus between the halo source, the exchange controller and the neighbor processor.
// The master side is the halo source / processor model; the slave side is the controller.
interface neighbor_exchange_controller_if #(
    parameter int RW     = 8,
    parameter int DATA_W = 8
);
    import utils::*;

    logic                                    in_valid;
    logic                                    in_ready;
    logic [NEIGHBOR_LANES-1:0][DATA_W-1:0]   in_value;
    logic [NEIGHBOR_LANES-1:0][RW-1:0]       in_row;
    logic [NEIGHBOR_LANES-1:0][RW-1:0]       in_column;
    logic [NEIGHBOR_LANES-1:0]               in_lane_valid;
    logic                                    leftover_inputs;
    logic [NEIGHBOR_LANES-1:0][DATA_W-1:0]   neighbor_input_value;
    logic [NEIGHBOR_LANES-1:0][RW-1:0]       neighbor_input_row;
    logic [NEIGHBOR_LANES-1:0][RW-1:0]       neighbor_input_column;
    logic [NEIGHBOR_LANES-1:0]               neighbor_input_write_enable;

    modport master (
        output in_valid, in_value, in_row, in_column, in_lane_valid, leftover_inputs,
        input  in_ready, neighbor_input_value, neighbor_input_row, neighbor_input_column,
               neighbor_input_write_enable
    );

    modport slave (
        input  in_valid, in_value, in_row, in_column, in_lane_valid, leftover_inputs,
        output in_ready, neighbor_input_value, neighbor_input_row, neighbor_input_column,
               neighbor_input_write_enable
    );

endinterface

// File: rtl/neighbor_exchange_controller_popcount.sv
// Combinational count of set lanes in an 8-lane enable mask.
module lane_popcount
    import utils::*;
(
    input  logic [NEIGHBOR_LANES-1:0] lanes,
    output logic [3:0]                count
);

    // Sum the lane bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < NEIGHBOR_LANES; i++) begin
            count = count + {3'b000, lanes[i]};
        end
    end

endmodule

// File: rtl/neighbor_exchange_controller.sv
// Neighbor exchange controller: accepts halo batches, trims them to the tile's expected
// lane count, and feeds a single-entry output register to the neighbor processor, holding
// it while the processor reports leftover (bank-conflict) work.
module neighbor_exchange_controller
    import utils::*;
#(
    parameter  int TILE_SIZE = 256,
    parameter  int LANES     = NEIGHBOR_LANES,
    parameter  int DATA_W    = 8,
    localparam int RW        = $clog2(TILE_SIZE)
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [15:0]                  expected_count,
    input  logic [1:0]                   bitwidth_in,
    neighbor_exchange_controller_if.slave bus,
    output logic [1:0]                   bitwidth,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [15:0]                  accepted_count,
    output logic [15:0]                  stall_cycles
);

    // Keep only the lowest-indexed valid lanes that still fit in the remaining room.
    function automatic logic [LANES-1:0] mask_lanes(input logic [LANES-1:0] lv,
                                                    input logic [15:0]      room);
        logic [LANES-1:0] m;
        logic [15:0]      taken;
        m     = '0;
        taken = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lv[i] && (taken < room)) begin
                m[i]  = 1'b1;
                taken = taken + 16'd1;
            end
        end
        return m;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    xchg_state_t state_q, state_d;

    logic [15:0]                 exp_q;
    logic [15:0]                 acc_q;
    logic [15:0]                 stall_q;
    logic                        ovf_q;
    logic [1:0]                  bw_q;
    logic [LANES-1:0][DATA_W-1:0] val_q;
    logic [LANES-1:0][RW-1:0]    row_q;
    logic [LANES-1:0][RW-1:0]    col_q;
    logic [LANES-1:0]            we_q;

    logic [3:0]       pop_we;
    logic [3:0]       pop_load;
    logic [LANES-1:0] load_mask;
    logic             occupied;
    logic             consume;
    logic             in_ready_c;
    logic             load;
    logic [15:0]      committed;
    logic [15:0]      remaining;
    logic [15:0]      committed_next;

    lane_popcount u_pop_we   (.lanes(we_q),      .count(pop_we));
    lane_popcount u_pop_load (.lanes(load_mask), .count(pop_load));

    // Lanes in the output register are already committed to the tile, consumed or not.
    assign occupied       = |we_q;
    assign consume        = occupied && !bus.leftover_inputs;
    assign committed      = acc_q + 16'(pop_we);
    assign remaining      = exp_q - committed;
    assign load_mask      = mask_lanes(bus.in_lane_valid, remaining);
    assign in_ready_c     = (state_q == RUN) && !abort && (remaining != 16'd0)
                            && (!occupied || consume);
    assign load           = in_ready_c && bus.in_valid;
    assign committed_next = committed + (load ? 16'(pop_load) : 16'd0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort wins over everything including start.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (committed_next == exp_q) state_d = DRAIN;
                DRAIN:   if (!occupied && !bus.leftover_inputs) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register, counters and latched tile parameters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q   <= '0;
            acc_q   <= '0;
            stall_q <= '0;
            ovf_q   <= 1'b0;
            bw_q    <= '0;
            val_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= '0;
        end else begin
            if (bus.leftover_inputs && occupied) stall_q <= sat_inc(stall_q);
            if (abort) begin
                we_q <= '0;
            end else if ((state_q == IDLE) && start) begin
                exp_q   <= expected_count;
                bw_q    <= bitwidth_in;
                acc_q   <= '0;
                stall_q <= '0;
                ovf_q   <= 1'b0;
                val_q   <= '0;
                row_q   <= '0;
                col_q   <= '0;
                we_q    <= '0;
            end else begin
                if (consume) acc_q <= acc_q + 16'(pop_we);
                if (load) begin
                    val_q <= bus.in_value;
                    row_q <= bus.in_row;
                    col_q <= bus.in_column;
                    we_q  <= load_mask;
                    if (load_mask != bus.in_lane_valid) ovf_q <= 1'b1;
                end else if (consume) begin
                    we_q <= '0;
                end
            end
        end
    end

    assign bus.in_ready                    = in_ready_c;
    assign bus.neighbor_input_value        = val_q;
    assign bus.neighbor_input_row          = row_q;
    assign bus.neighbor_input_column       = col_q;
    assign bus.neighbor_input_write_enable = we_q;

    assign bitwidth       = bw_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign overflow       = ovf_q;
    assign accepted_count = acc_q;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_neighbor_exchange_controller.sv
// Directed bench for neighbor_exchange_controller with a batch scoreboard.
module tb_neighbor_exchange_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] expected_count;
    logic [1:0]  bitwidth_in;
    logic [1:0]  bitwidth;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] accepted_count;
    logic [15:0] stall_cycles;

    neighbor_exchange_controller_if #(.RW(8), .DATA_W(8)) bus();

    neighbor_exchange_controller #(.TILE_SIZE(256), .LANES(8), .DATA_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .expected_count (expected_count),
        .bitwidth_in    (bitwidth_in),
        .bus            (bus),
        .bitwidth       (bitwidth),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .accepted_count (accepted_count),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  we;
        logic [63:0] val;
        logic [63:0] row;
    } batch_t;

    batch_t sb_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    int     consumes = 0;
    int     last_consume_cyc = 0;
    int     prev_consume_cyc = 0;
    int     tb_remaining = 0;
    bit     done_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumption monitor: the processor takes a batch whenever write_enable!=0 and no leftover.
    initial begin
        batch_t b;
        forever begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (reset_n && (bus.neighbor_input_write_enable != 8'h00) && !bus.leftover_inputs) begin
                prev_consume_cyc = last_consume_cyc;
                last_consume_cyc = cyc;
                consumes++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'(bus.neighbor_input_write_enable), 64'h0);
                end else begin
                    b = sb_q.pop_front();
                    chk("sb_we",  64'(bus.neighbor_input_write_enable), 64'(b.we));
                    chk("sb_val", bus.neighbor_input_value, b.val);
                    chk("sb_row", bus.neighbor_input_row, b.row);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [15:0] exp, input logic [1:0] bw);
        expected_count = exp;
        bitwidth_in    = bw;
        start          = 1'b1;
        tick();
        start          = 1'b0;
        tb_remaining   = int'(exp);
    endtask

    // Present a batch, wait (bounded) for acceptance, and queue the expected trimmed batch.
    task automatic send_batch(input logic [7:0] lv, input logic [7:0] base);
        logic [7:0] m;
        int         taken;
        int         n;
        bit         ok;
        batch_t     b;
        bus.in_valid      = 1'b1;
        bus.in_lane_valid = lv;
        for (int i = 0; i < 8; i++) begin
            bus.in_value[i]  = base + 8'(i);
            bus.in_row[i]    = base ^ 8'(i * 3);
            bus.in_column[i] = ~(base + 8'(i));
        end
        m     = 8'h00;
        taken = 0;
        for (int i = 0; i < 8; i++) begin
            if (lv[i] && (taken < tb_remaining)) begin
                m[i]  = 1'b1;
                taken = taken + 1;
            end
        end
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'h0, 64'h1);
            bus.in_valid = 1'b0;
        end else begin
            tick();
            bus.in_valid = 1'b0;
            tb_remaining = tb_remaining - taken;
            if (m != 8'h00) begin
                b.we  = m;
                b.val = bus.in_value;
                b.row = bus.in_row;
                sb_q.push_back(b);
            end
        end
    endtask

    task automatic wait_done(output int dcyc);
        bit found;
        found = 1'b0;
        dcyc  = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (done) begin
                found = 1'b1;
                dcyc  = cyc;
            end else begin
                tick();
            end
        end
        if (!found) chk("done_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        int d;
        int c0;
        logic [63:0] held_val;

        reset_n            = 1'b1;
        start              = 1'b0;
        abort              = 1'b0;
        expected_count     = '0;
        bitwidth_in        = '0;
        bus.in_valid       = 1'b0;
        bus.in_value       = '0;
        bus.in_row         = '0;
        bus.in_column      = '0;
        bus.in_lane_valid  = '0;
        bus.leftover_inputs = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy",     64'(busy), 64'h0);
        chk("rst_done",     64'(done), 64'h0);
        chk("rst_ready",    64'(bus.in_ready), 64'h0);
        chk("rst_we",       64'(bus.neighbor_input_write_enable), 64'h0);
        chk("rst_acc",      64'(accepted_count), 64'h0);
        chk("rst_stall",    64'(stall_cycles), 64'h0);
        chk("rst_ovf",      64'(overflow), 64'h0);
        chk("rst_bw",       64'(bitwidth), 64'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Two full batches, no leftover.
        start_tile(16'd16, 2'd2);
        chk("a_busy",  64'(busy), 64'h1);
        chk("a_bw",    64'(bitwidth), 64'h2);
        chk("a_ready", 64'(bus.in_ready), 64'h1);
        send_batch(8'hFF, 8'h10);
        send_batch(8'hFF, 8'h20);
        wait_done(d);
        chk("a_consec",   64'(last_consume_cyc - prev_consume_cyc), 64'd1);
        chk("a_done_lat", 64'(d - last_consume_cyc), 64'd2);
        chk("a_acc",      64'(accepted_count), 64'd16);
        chk("a_ovf",      64'(overflow), 64'h0);
        chk("a_stall",    64'(stall_cycles), 64'h0);
        tick();
        chk("a_done_pulse", 64'(done), 64'h0);
        chk("a_idle",       64'(busy), 64'h0);

        // Leftover held for three cycles after the first batch.
        start_tile(16'd16, 2'd0);
        c0 = consumes;
        send_batch(8'hFF, 8'h30);
        held_val = bus.neighbor_input_value;
        bus.leftover_inputs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_ready_low", 64'(bus.in_ready), 64'h0);
            chk("b_we_hold",   64'(bus.neighbor_input_write_enable), 64'hFF);
            chk("b_val_hold",  bus.neighbor_input_value, held_val);
            tick();
        end
        bus.leftover_inputs = 1'b0;
        send_batch(8'hFF, 8'h40);
        wait_done(d);
        chk("b_stall",    64'(stall_cycles), 64'd3);
        chk("b_acc",      64'(accepted_count), 64'd16);
        chk("b_consumes", 64'(consumes - c0), 64'd2);
        chk("b_sb_empty", 64'(sb_q.size()), 64'd0);
        tick();

        // Overflow trimming: 10 expected, 16 offered.
        start_tile(16'd10, 2'd1);
        send_batch(8'hFF, 8'h50);
        send_batch(8'hFF, 8'h60);
        chk("c_we_trim", 64'(bus.neighbor_input_write_enable), 64'h03);
        chk("c_ovf",     64'(overflow), 64'h1);
        wait_done(d);
        chk("c_acc",        64'(accepted_count), 64'd10);
        chk("c_ovf_sticky", 64'(overflow), 64'h1);
        tick();

        // Zero expected lanes: done two edges after the start edge, never ready.
        start_tile(16'd0, 2'd0);
        chk("d_ovf_clr", 64'(overflow), 64'h0);
        chk("d_ready0",  64'(bus.in_ready), 64'h0);
        chk("d_done0",   64'(done), 64'h0);
        tick();
        chk("d_ready1",  64'(bus.in_ready), 64'h0);
        chk("d_done1",   64'(done), 64'h0);
        tick();
        chk("d_done2",   64'(done), 64'h1);
        tick();
        chk("d_done3",   64'(done), 64'h0);

        // Abort with a batch in the register and another offered.
        start_tile(16'd16, 2'd0);
        send_batch(8'h0F, 8'h70);
        bus.in_valid      = 1'b1;
        bus.in_lane_valid = 8'hFF;
        abort             = 1'b1;
        @(negedge clk);
        chk("e_ready_abort", 64'(bus.in_ready), 64'h0);
        tick();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        chk("e_we_clr", 64'(bus.neighbor_input_write_enable), 64'h0);
        chk("e_idle",   64'(busy), 64'h0);
        sb_q.delete();
        start_tile(16'd8, 2'd3);
        chk("e_restart", 64'(busy), 64'h1);
        expected_count = 16'd99;
        start          = 1'b1;
        tick();
        start          = 1'b0;
        send_batch(8'hFF, 8'h80);
        wait_done(d);
        chk("e_acc", 64'(accepted_count), 64'd8);
        tick();
        expected_count = 16'd5;
        start          = 1'b1;
        abort          = 1'b1;
        tick();
        start          = 1'b0;
        abort          = 1'b0;
        chk("e_abort_wins", 64'(busy), 64'h0);

        // Asynchronous reset in DRAIN with a held batch.
        start_tile(16'd16, 2'd1);
        send_batch(8'hFF, 8'h90);
        send_batch(8'hFF, 8'hA0);
        bus.leftover_inputs = 1'b1;
        done_seen = 1'b0;
        chk("f_busy", 64'(busy), 64'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("f_we",    64'(bus.neighbor_input_write_enable), 64'h0);
        chk("f_val",   bus.neighbor_input_value, 64'h0);
        chk("f_busy0", 64'(busy), 64'h0);
        chk("f_ready", 64'(bus.in_ready), 64'h0);
        chk("f_acc",   64'(accepted_count), 64'h0);
        chk("f_bw",    64'(bitwidth), 64'h0);
        tick();
        reset_n = 1'b1;
        bus.leftover_inputs = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 5; i++) tick();
        chk("f_no_done",  64'(done_seen), 64'h0);
        chk("f_no_issue", 64'(bus.neighbor_input_write_enable), 64'h0);
        chk("f_idle",     64'(busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
